// File: rtl/univ_shift_pkg.sv
// Shared definitions for the universal shift register: mode select codes
// and the serialiser state encoding.
package univ_shift_pkg;

    localparam logic [2:0] MODE_HOLD  = 3'b000;
    localparam logic [2:0] MODE_LOAD  = 3'b001;
    localparam logic [2:0] MODE_SHL   = 3'b010;
    localparam logic [2:0] MODE_SHR   = 3'b011;
    localparam logic [2:0] MODE_ROL   = 3'b100;
    localparam logic [2:0] MODE_ROR   = 3'b101;
    localparam logic [2:0] MODE_CLEAR = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/univ_shift_core.sv
// Combinational next-value function of the register for each mode-select code.
module univ_shift_core
    import univ_shift_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] value,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] load_value,
    input  logic             serial_in_l,
    input  logic             serial_in_r,
    output logic [WIDTH-1:0] next_value
);

    // The reserved code 111 falls into the default branch and holds the value.
    always_comb begin
        next_value = value;
        case (mode)
            MODE_HOLD:  next_value = value;
            MODE_LOAD:  next_value = load_value;
            MODE_SHL:   next_value = {value[WIDTH-2:0], serial_in_l};
            MODE_SHR:   next_value = {serial_in_r, value[WIDTH-1:1]};
            MODE_ROL:   next_value = {value[WIDTH-2:0], value[WIDTH-1]};
            MODE_ROR:   next_value = {value[0], value[WIDTH-1:1]};
            MODE_CLEAR: next_value = '0;
            default:    next_value = value;
        endcase
    end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal register with mode-selected operations and an autonomous
// parallel-to-serial engine reporting busy/done.
module univ_shift_reg
    import univ_shift_pkg::*;
#(
    parameter int             WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter bit             MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] parallel_in,
    input  logic             serial_in_l,
    input  logic             serial_in_r,
    input  logic             start,
    output logic [WIDTH-1:0] parallel_out,
    output logic             serial_out,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH);

    state_t           state;
    state_t           state_next;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_next;
    logic [WIDTH-1:0] data;
    logic [WIDTH-1:0] data_next;
    logic [WIDTH-1:0] mode_value;

    univ_shift_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .value      (data),
        .mode       (mode),
        .load_value (parallel_in),
        .serial_in_l(serial_in_l),
        .serial_in_r(serial_in_r),
        .next_value (mode_value)
    );

    // While shifting, the register drains toward the output end with zero fill,
    // so it is empty by the time DONE is reached.
    always_comb begin
        state_next = state;
        count_next = count;
        data_next  = data;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    data_next  = parallel_in;
                    count_next = '0;
                    state_next = ST_SHIFT;
                end else begin
                    data_next = mode_value;
                end
            end
            ST_SHIFT: begin
                data_next  = MSB_FIRST ? {data[WIDTH-2:0], 1'b0}
                                       : {1'b0, data[WIDTH-1:1]};
                count_next = count + CW'(1);
                if (count == CW'(WIDTH - 1)) begin
                    count_next = '0;
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (start) begin
                    data_next  = parallel_in;
                    count_next = '0;
                    state_next = ST_SHIFT;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            count <= '0;
            data  <= RESET_VAL;
        end else begin
            state <= state_next;
            count <= count_next;
            data  <= data_next;
        end
    end

    assign parallel_out = data;
    assign serial_out   = MSB_FIRST ? data[WIDTH-1] : data[0];
    assign busy         = (state == ST_SHIFT);
    assign done         = (state == ST_DONE);

endmodule

// File: tb/tb_univ_shift_reg.sv
// Scoreboard bench: MSB-first and LSB-first instances share one stimulus stream
// and are checked every cycle against an arithmetic reference model.
module tb_univ_shift_reg;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] mode;
    logic [7:0] parallel_in;
    logic       serial_in_l;
    logic       serial_in_r;
    logic       start;

    logic [7:0] po_m, po_l;
    logic       so_m, so_l, busy_m, busy_l, done_m, done_l;

    typedef struct {
        logic [7:0] po;
        logic       so;
        logic       busy;
        logic       done;
    } exp_t;

    exp_t exp_q[2][$];

    int vectors     = 0;
    int miscompares = 0;

    int         model_phase[2];
    logic [7:0] model_val[2];
    logic [7:0] model_word[2];

    always #5 clk = ~clk;

    univ_shift_reg #(.WIDTH(8), .RESET_VAL(8'h00), .MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .reset(reset), .mode(mode), .parallel_in(parallel_in),
        .serial_in_l(serial_in_l), .serial_in_r(serial_in_r), .start(start),
        .parallel_out(po_m), .serial_out(so_m), .busy(busy_m), .done(done_m)
    );

    univ_shift_reg #(.WIDTH(8), .RESET_VAL(8'h00), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .reset(reset), .mode(mode), .parallel_in(parallel_in),
        .serial_in_l(serial_in_l), .serial_in_r(serial_in_r), .start(start),
        .parallel_out(po_l), .serial_out(so_l), .busy(busy_l), .done(done_l)
    );

    function automatic logic [7:0] apply_mode(input logic [7:0] v, input logic [2:0] m,
                                              input logic [7:0] p, input logic sl,
                                              input logic sr);
        int x;
        int r;
        x = int'(v);
        case (m)
            3'd1:    r = int'(p);
            3'd2:    r = (x * 2 + int'(sl)) % 256;
            3'd3:    r = x / 2 + int'(sr) * 128;
            3'd4:    r = (x * 2) % 256 + x / 128;
            3'd5:    r = x / 2 + (x % 2) * 128;
            3'd6:    r = 0;
            default: r = x;
        endcase
        return 8'(r);
    endfunction

    task automatic applyStimulus(input logic rst, input logic [2:0] m, input logic [7:0] p,
                                 input logic st, input logic sl, input logic sr);
        exp_t e;
        bit   msb;
        int   k;
        @(negedge clk);
        reset       = rst;
        mode        = m;
        parallel_in = p;
        start       = st;
        serial_in_l = sl;
        serial_in_r = sr;
        for (int i = 0; i < 2; i++) begin
            msb = (i == 0);
            if (rst) begin
                model_val[i]   = 8'h00;
                model_phase[i] = -1;
            end else if (model_phase[i] >= 0 && model_phase[i] <= 7) begin
                model_phase[i] = model_phase[i] + 1;
                k = model_phase[i];
                model_val[i] = msb ? 8'((int'(model_word[i]) * (1 << k)) % 256)
                                   : 8'(int'(model_word[i]) / (1 << k));
            end else if (st) begin
                model_word[i]  = p;
                model_val[i]   = p;
                model_phase[i] = 0;
            end else if (model_phase[i] == 8) begin
                model_phase[i] = -1;
            end else begin
                model_val[i] = apply_mode(model_val[i], m, p, sl, sr);
            end
            k      = model_phase[i];
            e.po   = model_val[i];
            e.busy = (k >= 0 && k <= 7);
            e.done = (k == 8);
            if (e.busy) e.so = msb ? model_word[i][7 - k] : model_word[i][k];
            else        e.so = msb ? model_val[i][7] : model_val[i][0];
            exp_q[i].push_back(e);
        end
    endtask

    task automatic checkOutput(input string name, input logic [7:0] actual,
                               input logic [7:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s at %0t: got 0x%02h, expected 0x%02h",
                     name, $time, actual, expected);
        end
    endtask

    // Monitor: one expected response per DUT per clock edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q[0].size() > 0) begin
                e = exp_q[0].pop_front();
                checkOutput("msb.parallel_out", po_m, e.po);
                checkOutput("msb.serial_out", {7'd0, so_m}, {7'd0, e.so});
                checkOutput("msb.busy", {7'd0, busy_m}, {7'd0, e.busy});
                checkOutput("msb.done", {7'd0, done_m}, {7'd0, e.done});
            end
            if (exp_q[1].size() > 0) begin
                e = exp_q[1].pop_front();
                checkOutput("lsb.parallel_out", po_l, e.po);
                checkOutput("lsb.serial_out", {7'd0, so_l}, {7'd0, e.so});
                checkOutput("lsb.busy", {7'd0, busy_l}, {7'd0, e.busy});
                checkOutput("lsb.done", {7'd0, done_l}, {7'd0, e.done});
            end
        end
    end

    initial begin
        int waited;
        reset = 1'b1; mode = 3'd0; parallel_in = 8'h00;
        start = 1'b0; serial_in_l = 1'b0; serial_in_r = 1'b0;
        model_phase = '{-1, -1};
        model_val   = '{8'h00, 8'h00};
        model_word  = '{8'h00, 8'h00};

        $display("[TB] reset");
        applyStimulus(1, 3'd0, 8'h00, 0, 0, 0);
        applyStimulus(0, 3'd0, 8'h00, 0, 0, 0);

        $display("[TB] load / hold / reserved");
        applyStimulus(0, 3'd1, 8'hA5, 0, 0, 0);
        repeat (3) applyStimulus(0, 3'd0, 8'h3C, 0, 1, 1);
        applyStimulus(0, 3'd7, 8'h3C, 0, 1, 1);

        $display("[TB] shift / rotate / clear");
        applyStimulus(0, 3'd1, 8'hA5, 0, 0, 0);
        applyStimulus(0, 3'd2, 8'h00, 0, 1, 0);
        applyStimulus(0, 3'd1, 8'hA5, 0, 0, 0);
        applyStimulus(0, 3'd3, 8'h00, 0, 1, 0);
        applyStimulus(0, 3'd1, 8'h81, 0, 0, 0);
        applyStimulus(0, 3'd4, 8'h00, 0, 0, 0);
        applyStimulus(0, 3'd1, 8'h81, 0, 0, 0);
        applyStimulus(0, 3'd5, 8'h00, 0, 0, 0);
        applyStimulus(0, 3'd6, 8'h00, 0, 0, 0);

        $display("[TB] serialise 0xB4");
        applyStimulus(0, 3'd0, 8'hB4, 1, 0, 0);
        repeat (10) applyStimulus(0, 3'd0, 8'h00, 0, 0, 0);

        $display("[TB] inputs ignored while busy");
        applyStimulus(0, 3'd0, 8'h5A, 1, 0, 0);
        repeat (3) applyStimulus(0, 3'd0, 8'h00, 0, 0, 0);
        applyStimulus(0, 3'd6, 8'hFF, 1, 1, 1);
        repeat (8) applyStimulus(0, 3'd0, 8'h00, 0, 0, 0);

        $display("[TB] reset mid-transfer");
        applyStimulus(0, 3'd0, 8'hC3, 1, 0, 0);
        repeat (3) applyStimulus(0, 3'd0, 8'h00, 0, 0, 0);
        applyStimulus(1, 3'd0, 8'h00, 0, 0, 0);
        repeat (12) applyStimulus(0, 3'd0, 8'h00, 0, 0, 0);

        $display("[TB] back-to-back transfers");
        applyStimulus(0, 3'd0, 8'hE7, 1, 0, 0);
        repeat (7) applyStimulus(0, 3'd0, 8'h00, 0, 0, 0);
        applyStimulus(0, 3'd0, 8'h0F, 1, 0, 0);
        repeat (10) applyStimulus(0, 3'd0, 8'h00, 0, 0, 0);

        $display("[TB] randomized traffic");
        for (int n = 0; n < 3000; n++) begin
            applyStimulus(($urandom % 64) == 0, 3'($urandom), 8'($urandom),
                          ($urandom % 6) == 0, 1'($urandom), 1'($urandom));
        end

        waited = 0;
        while ((exp_q[0].size() > 0 || exp_q[1].size() > 0) && waited < 10) begin
            @(posedge clk);
            waited++;
        end
        #2;
        if (exp_q[0].size() > 0 || exp_q[1].size() > 0) begin
            miscompares++;
            $display("[TB] FAIL drain: %0d responses left, expected 0",
                     exp_q[0].size() + exp_q[1].size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/univ_shift_reg.md
Name: univ_shift_reg

Overview:
Parametrised universal register that generalises the 3-bit parallel-in/parallel-out register. Adds a configurable width, a synchronous mode select (hold, load, shift, rotate and clear) and an autonomous parallel-to-serial engine with a busy/done handshake. It sits between datapath registers and serial links such as SPI-style transmitters and test-pattern chains.

Parameters:
- WIDTH, 8: register width in bits; must be at least 2.
- RESET_VAL, 0: value of parallel_out after reset; WIDTH bits wide.
- MSB_FIRST, 1: serialiser order. 1 shifts left and emits the MSB first; 0 shifts right and emits the LSB first.

Ports:
- clk  in  1: rising-edge clock.
- reset  in  1: synchronous, active-high reset.
- mode  in  3: operation select, applied only while the serialiser is idle.
- parallel_in  in  WIDTH: load data, used by mode LOAD and by start.
- serial_in_l  in  1: bit that enters the LSB on SHL.
- serial_in_r  in  1: bit that enters the MSB on SHR.
- start  in  1: pulse that begins a serialisation of parallel_in.
- parallel_out  out  WIDTH: registered contents.
- serial_out  out  1: MSB of the register if MSB_FIRST=1, otherwise the LSB.
- busy  out  1: high while serialisation bits are being presented.
- done  out  1: single-cycle pulse when serialisation completes.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset, on the next clk edge:
  - parallel_out = RESET_VAL;
  - FSM goes to IDLE;
  - bit counter = 0;
  - busy = 0 and done = 0.
- Reset asserted mid-serialisation aborts the transfer. No done pulse is produced.
- Mode encoding, all operations registered with 1-cycle latency:
  - 000 HOLD: register unchanged.
  - 001 LOAD: register takes parallel_in.
  - 010 SHL: register takes {reg[W-2:0], serial_in_l}.
  - 011 SHR: register takes {serial_in_r, reg[W-1:1]}.
  - 100 ROL: rotate left by one.
  - 101 ROR: rotate right by one.
  - 110 CLEAR: register takes all zeros.
  - 111: reserved, behaves as HOLD.
- serial_out is combinational from the register. It is valid in every state.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - mode is executed each cycle.
  - If start=1, the register loads parallel_in, the counter is cleared and the FSM moves to SHIFT.
  - start has priority over mode in the same cycle.
- SHIFT:
  - busy=1 and mode is ignored.
  - Each cycle the register shifts one place toward the output end with a 0 fill (left if MSB_FIRST=1, right otherwise). The counter increments.
  - The FSM stays in SHIFT for exactly WIDTH cycles. In busy cycle k (k = 0..WIDTH-1), serial_out presents bit k of the stream.
  - When the counter reaches WIDTH-1, the FSM moves to DONE.
- DONE:
  - done=1 and busy=0 for exactly one cycle. The register now holds all zeros.
  - A start in DONE is accepted: parallel_in is loaded and the FSM goes to SHIFT, giving back-to-back transfers with a one-cycle gap.
  - With no start, the FSM returns to IDLE. mode is not executed in DONE.
- start during SHIFT is ignored and produces no queued request.
- Counter width is $clog2(WIDTH). Wrap beyond WIDTH-1 is not possible.

Decomposition:
- Package univ_shift_pkg holds:
  - the mode encoding constants (MODE_HOLD through MODE_CLEAR);
  - the FSM state enum (ST_IDLE, ST_SHIFT, ST_DONE).
- Sub-module univ_shift_core: a combinational next-value function (current value, mode, serial inputs → next value), parametrised by WIDTH.
- The top level holds the register, the FSM, the counter and the serialiser override.

Test Plan:
All scenarios use WIDTH=8, RESET_VAL=0 and MSB_FIRST=1 unless noted.
1. Reset: assert reset for 1 cycle → parallel_out=0x00, busy=0, done=0, serial_out=0.
2. LOAD then HOLD: LOAD 0xA5 → 0xA5 on the next cycle. HOLD for 3 cycles → remains 0xA5. Mode 111 → remains 0xA5.
3. Shift and rotate, each starting from a fresh load:
   - 0xA5 with SHL, serial_in_l=1 → 0x4B.
   - 0xA5 with SHR, serial_in_r=0 → 0x52.
   - 0x81 with ROL → 0x03.
   - 0x81 with ROR → 0xC0.
   - CLEAR → 0x00.
4. Serialise 0xB4:
   - start=1 with parallel_in=0xB4 → busy=1 for 8 cycles; serial_out = 1,0,1,1,0,1,0,0.
   - Then done=1 for 1 cycle, parallel_out=0x00, then IDLE.
   - Repeat with MSB_FIRST=0 → serial_out = 0,0,1,0,1,1,0,1.
5. Ignored inputs while busy: during busy cycle 3, drive start=1, parallel_in=0xFF and mode=CLEAR → stream unchanged, done arrives at the same cycle, no second transfer.
6. Reset and back-to-back transfers:
   - Reset in busy cycle 4 → next cycle busy=0, parallel_out=0x00, no done pulse ever.
   - start asserted in the DONE cycle with 0x0F → busy again on the next cycle, streaming 0,0,0,0,1,1,1,1.
